// File: rtl/tl_pkg.sv
// Shared encodings and decode helpers for the traffic light controller and monitor.
package tl_pkg;

  localparam logic [1:0] RED     = 2'b00;
  localparam logic [1:0] YELLOW  = 2'b01;
  localparam logic [1:0] GREEN   = 2'b10;
  localparam logic [1:0] INVALID = 2'b11;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } tl_state_e;

  // Exactly one lamp lit maps to a phase; anything else is INVALID.
  function automatic logic [1:0] tl_decode(input logic r, input logic y, input logic g);
    logic [1:0] ph;
    case ({r, y, g})
      3'b100:  ph = RED;
      3'b010:  ph = YELLOW;
      3'b001:  ph = GREEN;
      default: ph = INVALID;
    endcase
    return ph;
  endfunction

  function automatic logic [1:0] tl_next(input logic [1:0] ph);
    logic [1:0] nx;
    case (ph)
      RED:     nx = GREEN;
      GREEN:   nx = YELLOW;
      YELLOW:  nx = RED;
      default: nx = INVALID;
    endcase
    return nx;
  endfunction

endpackage

// File: rtl/tl_dwell_counter.sv
// Saturating per-phase dwell counter with a one-shot pulse on first exceeding MAX_DWELL.
module tl_dwell_counter #(
  parameter int CNT_W     = 8,
  parameter int MAX_DWELL = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load1,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             over_max
);

  logic do_inc;

  assign do_inc = inc && !clear && !load1;

  // Saturation keeps the count above MAX_DWELL, so equality fires only once per phase.
  assign over_max = do_inc && (count == CNT_W'(MAX_DWELL));

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load1) begin
      count <= CNT_W'(1);
    end else if (do_inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the three-lamp traffic light interface.
// Optional cycle counter: define TRAFFIC_LIGHT_MONITOR_CYCLE_COUNT_EN to build it.
module traffic_light_monitor
  import tl_pkg::*;
#(
  parameter int MIN_DWELL = 1,
  parameter int MAX_DWELL = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
  input  logic             err_clr,
  output logic             locked,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] dwell_cnt,
  output logic             lamp_err,
  output logic             seq_err,
  output logic             short_err,
  output logic             timeout_err,
  output logic [15:0]      cycle_cnt
);

  tl_state_e  state_q, state_d;
  logic [1:0] dec, phase_d;
  logic       load1, clear, inc, over_max;
  logic       set_lamp, set_seq, set_short;

  assign dec = tl_decode(red, yellow, green);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= UNLOCKED;
      phase   <= INVALID;
    end else begin
      state_q <= state_d;
      phase   <= phase_d;
    end
  end

  // NOTE: every signal gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase;
    load1     = 1'b0;
    clear     = 1'b0;
    inc       = 1'b0;
    set_lamp  = 1'b0;
    set_seq   = 1'b0;
    set_short = 1'b0;
    case (state_q)
      UNLOCKED: begin
        if (dec == RED) begin
          state_d = LOCKED;
          phase_d = RED;
          load1   = 1'b1;
        end
      end
      LOCKED: begin
        if (dec == phase) begin
          inc = 1'b1;
        end else if (dec == tl_next(phase)) begin
          phase_d   = dec;
          load1     = 1'b1;
          set_short = (dwell_cnt < CNT_W'(MIN_DWELL));
        end else begin
          set_lamp = (dec == INVALID);
          set_seq  = (dec != INVALID);
          state_d  = UNLOCKED;
          phase_d  = INVALID;
          clear    = 1'b1;
        end
      end
      default: begin
        state_d = UNLOCKED;
        phase_d = INVALID;
        clear   = 1'b1;
      end
    endcase
  end

  always_comb begin
    locked = (state_q == LOCKED);
  end

  tl_dwell_counter #(
    .CNT_W     (CNT_W),
    .MAX_DWELL (MAX_DWELL)
  ) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load1    (load1),
    .clear    (clear),
    .inc      (inc),
    .count    (dwell_cnt),
    .over_max (over_max)
  );

  // A newly detected error wins over a simultaneous err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lamp_err    <= 1'b0;
      seq_err     <= 1'b0;
      short_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      lamp_err    <= set_lamp  | (lamp_err    & ~err_clr);
      seq_err     <= set_seq   | (seq_err     & ~err_clr);
      short_err   <= set_short | (short_err   & ~err_clr);
      timeout_err <= over_max  | (timeout_err & ~err_clr);
    end
  end

`ifdef TRAFFIC_LIGHT_MONITOR_CYCLE_COUNT_EN
  logic cycle_done;

  assign cycle_done = (state_q == LOCKED) && (phase == YELLOW) && (dec == RED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if (cycle_done) begin
      cycle_cnt <= cycle_cnt + 16'd1;
    end
  end
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed self-checking bench for traffic_light_monitor (default and MIN_DWELL=2 instances).
module tb_traffic_light_monitor;
  import tl_pkg::*;

  logic        clk, rst;
  logic        red, yellow, green, err_clr;
  logic        r2, y2, g2, clr2;

  logic        locked, lamp_err, seq_err, short_err, timeout_err;
  logic [1:0]  phase;
  logic [7:0]  dwell_cnt;
  logic [15:0] cycle_cnt;

  logic        locked2, lamp_err2, seq_err2, short_err2, timeout_err2;
  logic [1:0]  phase2;
  logic [7:0]  dwell_cnt2;
  logic [15:0] cycle_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef TRAFFIC_LIGHT_MONITOR_CYCLE_COUNT_EN
  localparam logic [15:0] EXP_C1 = 16'd1;
  localparam logic [15:0] EXP_C3 = 16'd3;
`else
  localparam logic [15:0] EXP_C1 = 16'd0;
  localparam logic [15:0] EXP_C3 = 16'd0;
`endif

  traffic_light_monitor dut (
    .clk(clk), .rst(rst), .red(red), .yellow(yellow), .green(green), .err_clr(err_clr),
    .locked(locked), .phase(phase), .dwell_cnt(dwell_cnt), .lamp_err(lamp_err),
    .seq_err(seq_err), .short_err(short_err), .timeout_err(timeout_err), .cycle_cnt(cycle_cnt)
  );

  traffic_light_monitor #(.MIN_DWELL(2)) dut2 (
    .clk(clk), .rst(rst), .red(r2), .yellow(y2), .green(g2), .err_clr(clr2),
    .locked(locked2), .phase(phase2), .dwell_cnt(dwell_cnt2), .lamp_err(lamp_err2),
    .seq_err(seq_err2), .short_err(short_err2), .timeout_err(timeout_err2), .cycle_cnt(cycle_cnt2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic lamps(input logic r, input logic y, input logic g);
    red = r; yellow = y; green = g;
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] errs();
    return {12'd0, lamp_err, seq_err, short_err, timeout_err};
  endfunction

  initial begin
    clk = 1'b0; rst = 1'b1; err_clr = 1'b0;
    lamps(1'b0, 1'b0, 1'b0);
    r2 = 1'b0; y2 = 1'b0; g2 = 1'b0; clr2 = 1'b0;

    #7;
    check("rst_locked", {15'd0, locked}, 16'd0);
    check("rst_phase",  {14'd0, phase}, 16'd3);
    check("rst_dwell",  {8'd0, dwell_cnt}, 16'd0);
    check("rst_errs",   errs(), 16'd0);
    check("rst_cycle",  cycle_cnt, 16'd0);
    rst = 1'b0;

    // Normal cycle RED x2, GREEN x3, YELLOW x1, RED
    lamps(1, 0, 0); tick();
    check("lock_after_red", {15'd0, locked}, 16'd1);
    check("red_phase",      {14'd0, phase}, 16'd0);
    check("red_dwell1",     {8'd0, dwell_cnt}, 16'd1);
    tick();
    check("red_dwell2",     {8'd0, dwell_cnt}, 16'd2);
    lamps(0, 0, 1); tick();
    check("green_phase",    {14'd0, phase}, 16'd2);
    check("green_dwell1",   {8'd0, dwell_cnt}, 16'd1);
    tick(); tick();
    check("green_dwell3",   {8'd0, dwell_cnt}, 16'd3);
    lamps(0, 1, 0); tick();
    check("yellow_phase",   {14'd0, phase}, 16'd1);
    check("yellow_dwell1",  {8'd0, dwell_cnt}, 16'd1);
    lamps(1, 0, 0); tick();
    check("cycle_after1",   cycle_cnt, EXP_C1);
    check("cycle_noerr",    errs(), 16'd0);
    check("cycle_locked",   {15'd0, locked}, 16'd1);

    // Illegal lamp code while locked in RED
    lamps(1, 0, 1); tick();
    check("lamp_err_set",   {15'd0, lamp_err}, 16'd1);
    check("lamp_unlock",    {15'd0, locked}, 16'd0);
    check("lamp_phase",     {14'd0, phase}, 16'd3);
    check("lamp_dwell",     {8'd0, dwell_cnt}, 16'd0);
    lamps(1, 0, 0); tick();
    check("relock",         {15'd0, locked}, 16'd1);
    check("lamp_err_stick", {15'd0, lamp_err}, 16'd1);
    err_clr = 1'b1; tick();
    err_clr = 1'b0;
    check("lamp_err_clr",   {15'd0, lamp_err}, 16'd0);
    check("dwell_after_clr", {8'd0, dwell_cnt}, 16'd2);

    // RED -> YELLOW is out of order
    lamps(0, 1, 0); tick();
    check("seq_err_set",    {15'd0, seq_err}, 16'd1);
    check("seq_unlock",     {15'd0, locked}, 16'd0);
    check("seq_phase",      {14'd0, phase}, 16'd3);
    lamps(0, 0, 0); err_clr = 1'b1; tick();
    err_clr = 1'b0;
    check("unlocked_quiet", errs(), 16'd0);

    // RED held for 10 samples with MAX_DWELL = 8
    lamps(1, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 8) check("tmo_at8", {15'd0, timeout_err}, 16'd0);
      if (i == 9) check("tmo_at9", {15'd0, timeout_err}, 16'd1);
    end
    check("tmo_locked",     {15'd0, locked}, 16'd1);
    check("tmo_dwell10",    {8'd0, dwell_cnt}, 16'd10);

    // Asynchronous reset mid-GREEN
    lamps(0, 0, 1); tick();
    check("green_after_tmo", {14'd0, phase}, 16'd2);
    #2 rst = 1'b1;
    #1;
    check("arst_locked",    {15'd0, locked}, 16'd0);
    check("arst_phase",     {14'd0, phase}, 16'd3);
    check("arst_dwell",     {8'd0, dwell_cnt}, 16'd0);
    check("arst_errs",      errs(), 16'd0);
    check("arst_cycle",     cycle_cnt, 16'd0);
    #1 rst = 1'b0;
    lamps(1, 0, 0); tick();
    check("arst_relock",    {15'd0, locked}, 16'd1);

    // Three full cycles
    for (int k = 0; k < 3; k++) begin
      lamps(0, 0, 1); tick();
      lamps(0, 1, 0); tick();
      lamps(1, 0, 0); tick();
    end
    check("cycle_after3",   cycle_cnt, EXP_C3);
    check("cycle3_noerr",   errs(), 16'd0);

    // MIN_DWELL = 2 instance: RED x1 then GREEN is too short
    r2 = 1'b1; tick();
    check("d2_locked",      {15'd0, locked2}, 16'd1);
    r2 = 1'b0; g2 = 1'b1; tick();
    check("short_err_set",  {15'd0, short_err2}, 16'd1);
    check("short_no_seq",   {15'd0, seq_err2}, 16'd0);
    g2 = 1'b0; r2 = 1'b1; clr2 = 1'b1; tick();
    clr2 = 1'b0;
    check("clr_vs_seq",     {15'd0, seq_err2}, 16'd1);
    check("clr_short",      {15'd0, short_err2}, 16'd0);
    check("d2_unlocked",    {15'd0, locked2}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Receive-side checker for the three-lamp traffic light interface (`red`, `yellow`, `green`). It samples the lamp lines driven by a traffic light controller on the same clock and decodes them into a phase. It tracks dwell time per phase and flags illegal lamp codes, out-of-order sequences, too-short phases and stuck phases. It sits beside the controller in the intersection subsystem and feeds the fault/status register block.

## Interface
- `MIN_DWELL`, 1: minimum legal samples per phase before a change.
- `MAX_DWELL`, 8: maximum legal samples per phase; more raises a timeout.
- `CNT_W`, 8: dwell counter width; must satisfy `MAX_DWELL < 2**CNT_W - 1`.
- `clk` in 1: single clock; all sampling on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `red`, `yellow`, `green` in 1 each: lamp lines, synchronous to `clk`.
- `err_clr` in 1: one-cycle pulse that clears all sticky error flags.
- `locked` out 1: monitor is synchronised to the sequence.
- `phase` out 2: decoded phase. RED=00, YELLOW=01, GREEN=10, INVALID=11.
- `dwell_cnt` out CNT_W: samples spent in the current phase, saturating.
- `lamp_err` out 1: sticky flag for a lamp code that is not one-hot.
- `seq_err` out 1: sticky flag for an illegal phase transition.
- `short_err` out 1: sticky flag for a phase shorter than `MIN_DWELL`.
- `timeout_err` out 1: sticky flag for a phase longer than `MAX_DWELL`.
- `cycle_cnt` out 16: count of completed full cycles (see Configuration).

## Operation
- Decode rule: exactly one lamp high gives that phase. Zero lamps, or two or more lamps high, gives INVALID.
- Legal sequence: RED→GREEN→YELLOW→RED.
- FSM has two states, UNLOCKED and LOCKED.
- UNLOCKED:
  - Wait for a sampled RED.
  - On a sampled RED: go to LOCKED, set `phase`=RED, set `dwell_cnt`=1.
  - Samples other than RED are ignored. No error flags are raised in this state.
- LOCKED, each rising edge:
  - Decoded phase equals `phase`: `dwell_cnt` increments, saturating at all-ones. If the incremented value first exceeds `MAX_DWELL`, set `timeout_err`. Stay LOCKED.
  - Decoded phase is the legal successor: update `phase` and set `dwell_cnt`=1. If the old `dwell_cnt` < `MIN_DWELL`, set `short_err`. On a YELLOW→RED change, increment `cycle_cnt`.
  - Decoded phase is INVALID: set `lamp_err`, go to UNLOCKED, set `phase`=INVALID, set `dwell_cnt`=0.
  - Any other change: set `seq_err`, go to UNLOCKED, set `phase`=INVALID, set `dwell_cnt`=0.
- `err_clr` clears all four error flags. If a new error is detected in the same cycle, the set wins and that flag stays 1.
- A timeout does not unlock the monitor. Counting continues to saturation.
- `locked` = 1 exactly when the FSM is in LOCKED.

## Timing
- Reset values: `locked`=0, `phase`=11, `dwell_cnt`=0, all error flags 0, `cycle_cnt`=0.
- State after reset: UNLOCKED.
- Latency: one cycle. A lamp value sampled at edge N is reflected in every output after edge N.
- Asserting `rst` mid-operation immediately forces all reset values, independent of `clk`. The first RED sampled after `rst` deasserts relocks the monitor.
- `cycle_cnt` wraps modulo 2^16.
- `dwell_cnt` never wraps.

## Configuration
- Macro: `TRAFFIC_LIGHT_MONITOR_CYCLE_COUNT_EN`.
- Defined: the 16-bit cycle counter is built and behaves as described above.
- Undefined: no counter is built. `cycle_cnt` is tied to 0, and the port is kept so that instantiations are unchanged.

## Structure
- Shared package `tl_pkg` holds:
  - Phase localparams RED/YELLOW/GREEN/INVALID (2-bit).
  - FSM state encoding UNLOCKED/LOCKED.
  - Function `tl_decode(red, yellow, green)` returning a phase.
  - Function `tl_next(phase)` returning the legal successor phase.
- The controller side uses the same encodings.
- One sub-module, `tl_dwell_counter`:
  - Saturating CNT_W counter with `load1`, `clear` and `inc` controls.
  - Output `over_max` is a single pulse when the count first exceeds `MAX_DWELL`.

## Test plan
- Reset, then RED×2, GREEN×3, YELLOW×1, RED: `locked`=1 after the first RED, `dwell_cnt` reaches 2/3/1, `cycle_cnt`=1, no error flags.
- While locked in RED, drive red=1 and green=1 for one edge: `lamp_err`=1, `locked`=0, `phase`=11. Then RED relocks the monitor and `lamp_err` stays 1 until an `err_clr` pulse.
- RED→YELLOW: `seq_err`=1, `locked`=0.
- RED held for 10 samples with `MAX_DWELL`=8: `timeout_err`=1 after the 9th sample, `locked` stays 1, `dwell_cnt`=10.
- With `MIN_DWELL`=2, RED×1 then GREEN: `short_err`=1. Apply `err_clr` in the same cycle as a new `seq_err`: `seq_err`=1 and `short_err`=0.
- Assert `rst` mid-GREEN between clock edges: all outputs return to reset values immediately. With the macro undefined, `cycle_cnt` stays 0 across three full cycles.
